// File: rtl/hazard_scoreboard_if.sv
// Decode-side bundle between the D stage and the hazard scoreboard.
// The master drives the D instruction metadata and flush; the slave returns stall/forward/busy.
interface hazard_scoreboard_if #(
  parameter int NSTAGE = 3,
  parameter int NPORT  = 2,
  parameter int AW     = 5,
  parameter int TW     = 4
);
  localparam int LW = $clog2(NSTAGE + 1);

  logic                  d_valid;
  logic [NPORT*AW-1:0]   d_raddr;
  logic [NPORT-1:0]      d_ren;
  logic [NPORT*TW-1:0]   d_tuse;
  logic [AW-1:0]         d_waddr;
  logic                  d_wen;
  logic [TW-1:0]         d_tnew;
  logic                  d_md_op;
  logic                  d_md_start;
  logic                  d_md_div;
  logic                  d_eret;
  logic                  d_epc_wr;
  logic                  flush;

  logic                  stall;
  logic [NPORT*LW-1:0]   fwd_sel;
  logic                  md_busy;

  modport master (
    output d_valid, d_raddr, d_ren, d_tuse, d_waddr, d_wen, d_tnew,
           d_md_op, d_md_start, d_md_div, d_eret, d_epc_wr, flush,
    input  stall, fwd_sel, md_busy
  );

  modport slave (
    input  d_valid, d_raddr, d_ren, d_tuse, d_waddr, d_wen, d_tnew,
           d_md_op, d_md_start, d_md_div, d_eret, d_epc_wr, flush,
    output stall, fwd_sel, md_busy
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Hazard and forwarding controller beside decode: a shift-register record of write-back
// metadata for stages 1..NSTAGE drives the decode stall, operand forwarding and HI/LO busy window.
module hazard_scoreboard #(
  parameter int NSTAGE  = 3,
  parameter int NPORT   = 2,
  parameter int AW      = 5,
  parameter int TW      = 4,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic              clk,
  input  logic              reset,
  hazard_scoreboard_if.slave bus
);

  localparam int LW     = $clog2(NSTAGE + 1);
  localparam int MD_MAX = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int MW     = $clog2(MD_MAX + 1);

  typedef struct packed {
    logic          wen;
    logic [AW-1:0] addr;
    logic [TW-1:0] tnew;
    logic          epc;
  } entry_t;

  localparam entry_t EMPTY = '0;

  // Index 0 holds stage 1 (E); index NSTAGE-1 holds the oldest tracked stage.
  entry_t        entry_q [NSTAGE];
  entry_t        entry_d [NSTAGE];
  logic [MW-1:0] md_cnt_q, md_cnt_d;

  logic [AW-1:0] raddr [NPORT];
  logic [TW-1:0] tuse  [NPORT];

  logic                          data_haz;
  logic                          md_haz;
  logic                          epc_haz;
  logic                          stall;
  logic [NPORT-1:0][LW-1:0]      fwd;

  for (genvar p = 0; p < NPORT; p++) begin : g_port
    assign raddr[p] = bus.d_raddr[p*AW +: AW];
    assign tuse[p]  = bus.d_tuse[p*TW +: TW];
  end

  function automatic logic [TW-1:0] sat_dec(input logic [TW-1:0] t);
    return (t == '0) ? '0 : t - TW'(1);
  endfunction

  // Walking from the oldest stage to the youngest lets the youngest producer overwrite
  // the forward select, while any matching stage whose result is not yet ready raises the hazard.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    data_haz = 1'b0;
    fwd      = '0;
    for (int p = 0; p < NPORT; p++) begin
      for (int k = NSTAGE - 1; k >= 0; k--) begin
        if (bus.d_valid && bus.d_ren[p] && (raddr[p] != '0) &&
            entry_q[k].wen && (entry_q[k].addr == raddr[p])) begin
          fwd[p] = LW'(k + 1);
          if (tuse[p] < entry_q[k].tnew) data_haz = 1'b1;
        end
      end
    end
  end

  // An EPC write in the last tracked stage has committed, so only younger stages block eret.
  always_comb begin
    epc_haz = 1'b0;
    for (int k = 0; k < NSTAGE - 1; k++) begin
      if (entry_q[k].epc) epc_haz = 1'b1;
    end
    epc_haz = epc_haz && bus.d_valid && bus.d_eret;
  end

  assign md_haz      = bus.d_valid && bus.d_md_op && bus.md_busy;
  assign stall       = data_haz || md_haz || epc_haz;

  assign bus.stall   = stall;
  assign bus.fwd_sel = fwd;
  assign bus.md_busy = (md_cnt_q != '0);

  always_comb begin
    entry_d  = entry_q;
    md_cnt_d = md_cnt_q;

    if (bus.flush) begin
      for (int k = 0; k < NSTAGE; k++) entry_d[k] = EMPTY;
    end else begin
      for (int k = NSTAGE - 1; k > 0; k--) begin
        entry_d[k]      = entry_q[k-1];
        entry_d[k].tnew = sat_dec(entry_q[k-1].tnew);
      end
      // A stalled D instruction stays in D; stage 1 receives a bubble instead.
      if (bus.d_valid && !stall) begin
        entry_d[0] = '{wen: bus.d_wen, addr: bus.d_waddr, tnew: bus.d_tnew, epc: bus.d_epc_wr};
      end else begin
        entry_d[0] = EMPTY;
      end
    end

    // The countdown keeps running through a flush; only a fresh issue reloads it.
    if (bus.d_valid && bus.d_md_start && !stall && !bus.flush) begin
      md_cnt_d = bus.d_md_div ? MW'(DIV_LAT) : MW'(MUL_LAT);
    end else if (md_cnt_q != '0) begin
      md_cnt_d = md_cnt_q - MW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the scoreboard is a handful of control flops, not a RAM, so every entry is reset.
      for (int k = 0; k < NSTAGE; k++) entry_q[k] <= EMPTY;
      md_cnt_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every stage samples the pre-edge value of its neighbour.
      entry_q  <= entry_d;
      md_cnt_q <= md_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: each step drives D, queues the expected
// stall/forward/busy values, then pops and compares them against the DUT outputs.
module tb_hazard_scoreboard;

  localparam int NSTAGE  = 3;
  localparam int NPORT   = 2;
  localparam int AW      = 5;
  localparam int TW      = 4;
  localparam int MUL_LAT = 5;
  localparam int DIV_LAT = 10;
  localparam int LW      = $clog2(NSTAGE + 1);

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  hazard_scoreboard_if #(.NSTAGE(NSTAGE), .NPORT(NPORT), .AW(AW), .TW(TW)) bus ();

  hazard_scoreboard #(
    .NSTAGE(NSTAGE), .NPORT(NPORT), .AW(AW), .TW(TW),
    .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string          tag;
    logic           stall;
    logic [LW-1:0]  fwd0;
    logic [LW-1:0]  fwd1;
    logic           busy;
  } exp_t;

  exp_t exp_q[$];

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] req);
    checks++;
    assert (obs === req) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
    end
  endtask

  task automatic compare_out();
    exp_t e;
    e = exp_q.pop_front();
    check({e.tag, ".stall"}, 8'(bus.stall), 8'(e.stall));
    check({e.tag, ".fwd0"},  8'(bus.fwd_sel[0 +: LW]), 8'(e.fwd0));
    check({e.tag, ".fwd1"},  8'(bus.fwd_sel[LW +: LW]), 8'(e.fwd1));
    check({e.tag, ".busy"},  8'(bus.md_busy), 8'(e.busy));
  endtask

  task automatic expect_out(input string tag, input logic s, input int f0, input int f1, input logic b);
    exp_t e;
    e.tag   = tag;
    e.stall = s;
    e.fwd0  = LW'(f0);
    e.fwd1  = LW'(f1);
    e.busy  = b;
    exp_q.push_back(e);
    #1;
    compare_out();
  endtask

  task automatic clear_d();
    bus.d_valid    = 1'b0;
    bus.d_raddr    = '0;
    bus.d_ren      = '0;
    bus.d_tuse     = '0;
    bus.d_waddr    = '0;
    bus.d_wen      = 1'b0;
    bus.d_tnew     = '0;
    bus.d_md_op    = 1'b0;
    bus.d_md_start = 1'b0;
    bus.d_md_div   = 1'b0;
    bus.d_eret     = 1'b0;
    bus.d_epc_wr   = 1'b0;
  endtask

  task automatic add_rd(input int p, input int addr, input int tuse);
    bus.d_ren[p]              = 1'b1;
    bus.d_raddr[p*AW +: AW]   = AW'(addr);
    bus.d_tuse[p*TW +: TW]    = TW'(tuse);
  endtask

  task automatic put_wr(input int addr, input int tnew);
    clear_d();
    bus.d_valid = 1'b1;
    bus.d_wen   = 1'b1;
    bus.d_waddr = AW'(addr);
    bus.d_tnew  = TW'(tnew);
  endtask

  task automatic put_rd(input int p, input int addr, input int tuse);
    clear_d();
    bus.d_valid = 1'b1;
    add_rd(p, addr, tuse);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    clear_d();
    repeat (NSTAGE) tick();
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog expired before the sequence completed");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    bus.flush = 1'b0;
    clear_d();

    // Reset: hostile D inputs still see an empty scoreboard.
    bus.d_valid = 1'b1; bus.d_md_op = 1'b1; bus.d_eret = 1'b1;
    add_rd(0, 2, 0); add_rd(1, 3, 0);
    #1;
    expect_out("reset_a", 1'b0, 0, 0, 1'b0);
    tick();
    expect_out("reset_b", 1'b0, 0, 0, 1'b0);
    reset = 1'b0;
    clear_d();
    tick();

    // Load-use with tuse=0: two stall cycles, then forward from stage 3.
    put_wr(2, 2);           expect_out("lw0_issue", 1'b0, 0, 0, 1'b0); tick();
    put_rd(0, 2, 0);        expect_out("lw0_s1",    1'b1, 1, 0, 1'b0); tick();
                            expect_out("lw0_s2",    1'b1, 2, 0, 1'b0); tick();
                            expect_out("lw0_fwd3",  1'b0, 3, 0, 1'b0); tick();
    drain();

    // Load-use with tuse=1: one stall cycle, then forward from stage 2.
    put_wr(2, 2);           expect_out("lw1_issue", 1'b0, 0, 0, 1'b0); tick();
    put_rd(0, 2, 1);        expect_out("lw1_s1",    1'b1, 1, 0, 1'b0); tick();
                            expect_out("lw1_fwd2",  1'b0, 2, 0, 1'b0); tick();
    drain();

    // tuse=2 against tnew=2: no stall, forward from stage 1.
    put_wr(2, 2);           tick();
    put_rd(0, 2, 2);        expect_out("lw2_fwd1",  1'b0, 1, 0, 1'b0); tick();
    drain();

    // Two in-flight writers of $3: youngest (stage 1) wins on port 1.
    put_wr(3, 0);           tick();
    put_wr(3, 0);           tick();
    put_rd(1, 3, 0); add_rd(0, 5, 0);
                            expect_out("dup_young", 1'b0, 0, 1, 1'b0);
    bus.d_valid = 1'b0;     expect_out("dup_novld", 1'b0, 0, 0, 1'b0);
    drain();

    // Register $0 never matches, even with a pending writer of $0.
    put_wr(0, 3);           tick();
    put_rd(0, 0, 0); add_rd(1, 0, 0);
                            expect_out("reg0",      1'b0, 0, 0, 1'b0); tick();
    drain();

    // mult then mflo: busy and stall for MUL_LAT cycles, mflo issues after.
    clear_d(); bus.d_valid = 1'b1; bus.d_md_op = 1'b1; bus.d_md_start = 1'b1;
                            expect_out("mult_issue", 1'b0, 0, 0, 1'b0); tick();
    clear_d(); bus.d_valid = 1'b1; bus.d_md_op = 1'b1;
    for (int i = 0; i < MUL_LAT; i++) begin
      expect_out($sformatf("mflo_wait%0d", i), 1'b1, 0, 0, 1'b1);
      tick();
    end
                            expect_out("mflo_go",   1'b0, 0, 0, 1'b0); tick();
    drain();

    // Flush does not stop the countdown.
    clear_d(); bus.d_valid = 1'b1; bus.d_md_op = 1'b1; bus.d_md_start = 1'b1;
    tick();
    clear_d(); bus.flush = 1'b1;
                            expect_out("md_flush",  1'b0, 0, 0, 1'b1); tick();
    bus.flush = 1'b0;
                            expect_out("md_after_flush", 1'b0, 0, 0, 1'b1);
    repeat (3) tick();
                            expect_out("md_last",   1'b0, 0, 0, 1'b1); tick();
                            expect_out("md_done",   1'b0, 0, 0, 1'b0);

    // div then asynchronous reset in cycle 3 kills busy immediately.
    clear_d(); bus.d_valid = 1'b1; bus.d_md_op = 1'b1; bus.d_md_start = 1'b1; bus.d_md_div = 1'b1;
    tick();
    clear_d();              expect_out("div_c1",    1'b0, 0, 0, 1'b1); tick();
                            expect_out("div_c2",    1'b0, 0, 0, 1'b1); tick();
    reset = 1'b1;           expect_out("div_reset", 1'b0, 0, 0, 1'b0);
    tick();
    reset = 1'b0;
    tick();

    // mtc0 EPC then eret: stall while the write is in stages 1 and 2.
    clear_d(); bus.d_valid = 1'b1; bus.d_epc_wr = 1'b1;
                            expect_out("epc_issue", 1'b0, 0, 0, 1'b0); tick();
    clear_d(); bus.d_valid = 1'b1; bus.d_eret = 1'b1;
                            expect_out("eret_s1",   1'b1, 0, 0, 1'b0); tick();
                            expect_out("eret_s2",   1'b1, 0, 0, 1'b0); tick();
                            expect_out("eret_go",   1'b0, 0, 0, 1'b0); tick();
    drain();

    // Flush during a data stall: entries clear and the stalled writer of $7 is not inserted.
    put_wr(2, 2);           tick();
    put_rd(0, 2, 0); bus.d_wen = 1'b1; bus.d_waddr = AW'(7); bus.d_tnew = TW'(3);
    bus.flush = 1'b1;       expect_out("flush_stall", 1'b1, 1, 0, 1'b0); tick();
    bus.flush = 1'b0;
    put_rd(1, 7, 0); add_rd(0, 2, 0);
                            expect_out("flush_clear", 1'b0, 0, 0, 1'b0); tick();
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised hazard and forwarding controller for the in-order pipeline. It sits beside the decode stage and keeps a shift-register scoreboard of the write-back metadata of every instruction in stages 1..NSTAGE after D. From that record it produces the decode stall, a per-read-port forwarding select, and a multiply/divide busy window with configurable latency. It also blocks `eret` while a pending write to EPC is in flight.

## Interface
Parameters:
- NSTAGE, 3, number of tracked stages after D (1 = E, 2 = M, 3 = W).
- NPORT, 2, number of register read ports in D.
- AW, 5, register address width.
- TW, 4, Tnew/Tuse width.
- MUL_LAT, 5, cycles `md_busy` stays high after a multiply enters stage 1.
- DIV_LAT, 10, same as MUL_LAT, for divide.
- LW is derived, not a parameter: LW = $clog2(NSTAGE+1).

Ports:
- clk  in  1  clock. One clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high.
- d_valid  in  1  D holds a real instruction (no fetch/decode exception).
- d_raddr  in  NPORT*AW  source register per port; port p is bits [p*AW +: AW].
- d_ren  in  NPORT  port p actually reads its register.
- d_tuse  in  NPORT*TW  cycles until port p needs its operand.
- d_waddr  in  AW  destination register.
- d_wen  in  1  D instruction writes the GPR file.
- d_tnew  in  TW  cycles, counted from stage-1 entry, until the result is available.
- d_md_op  in  1  D instruction uses HI/LO (mult/div/mfhi/mflo/mthi/mtlo).
- d_md_start  in  1  D instruction starts the multiply/divide unit.
- d_md_div  in  1  the start is a divide (selects DIV_LAT).
- d_eret  in  1  D holds `eret`.
- d_epc_wr  in  1  D instruction writes CP0 EPC.
- flush  in  1  exception/eret flush of all tracked stages.
- stall  out  1  freeze PC and D; insert a bubble into stage 1.
- fwd_sel  out  NPORT*LW  per port: 0 = register file, k = forward from stage k.
- md_busy  out  1  the multiply/divide countdown is non-zero.

## Operation
Each stage k (1..NSTAGE) holds one scoreboard entry: {wen, addr, tnew, epc}.

Entry shift, applied at every clock edge in this priority order:
- reset: all entries cleared (wen=0, epc=0, tnew=0); md_cnt cleared to 0.
- flush: all entries cleared. md_cnt keeps counting down.
- otherwise: entry[k+1] ← entry[k] with tnew decremented, saturating at 0.
  - The entry leaving stage NSTAGE is dropped.
  - entry[1] ← {d_wen, d_waddr, d_tnew, d_epc_wr} if d_valid && !stall; otherwise a bubble.

Match rule:
- Port p matches stage k when all of the following hold: d_valid, d_ren[p], entry[k].wen, entry[k].addr == raddr[p], raddr[p] != 0.
- Register 0 never matches, never stalls and never forwards.

Stall sources:
- Data: some port p matches some stage k with d_tuse[p] < entry[k].tnew.
- MD: d_valid && d_md_op && md_busy.
- EPC: d_valid && d_eret && entry[k].epc for any k < NSTAGE.
- stall is the OR of all three.

Forwarding:
- fwd_sel[p] is the smallest k that matches port p, so the youngest producer wins.
- fwd_sel[p] = 0 if no stage matches, or if d_valid = 0.
- fwd_sel is meaningful only when stall = 0.

MD counter (md_cnt, width $clog2(max(MUL_LAT,DIV_LAT)+1)):
- Loads DIV_LAT or MUL_LAT (chosen by d_md_div) on an edge where d_valid && d_md_start && !stall && !flush && !reset.
- Otherwise decrements toward 0 and holds at 0.
- md_busy = (md_cnt != 0).

## Timing
- stall, fwd_sel and md_busy are combinational from the registered state plus the current D inputs; there is no added latency.
- Reset values: all entries cleared, md_cnt = 0. Therefore md_busy = 0 and stall = 0 with fwd_sel = 0 for any D inputs.
- A D instruction is visible in entry[1] one edge after it leaves D.
- A multiply started in D keeps md_busy high for exactly MUL_LAT cycles, beginning the cycle it occupies stage 1.
- stall and flush together: flush wins, entries clear, and the stalled D instruction is not inserted.
- Reset asserted mid-divide clears md_busy immediately (asynchronous), not at the next clock edge.
- A stall whose condition clears does not persist: stall deasserts in the same cycle the condition clears.

## Test plan
- `lw $2` (d_tnew=2) enters stage 1; next D reads $2 on port 0 with tuse=0 → stall high for 2 cycles, then stall=0 with fwd_sel[0]=3.
- Same sequence with tuse=1 → stall high for 1 cycle, then fwd_sel[0]=2. Reading $2 with tuse=2 → no stall, fwd_sel[0]=1.
- Stages 1 and 2 both write $3 with tnew=0; D reads $3 on port 1 → stall=0, fwd_sel[1]=1. D reads $0 while stage 1 writes $0 → fwd_sel=0, stall=0.
- mult issued (MUL_LAT=5) followed immediately by mflo → md_busy and stall high for 5 cycles, mflo issues in cycle 6. A div followed by reset in cycle 3 → md_busy=0 immediately.
- mtc0 EPC enters stage 1, then `eret` arrives in D → stall for 2 cycles (entry in stages 1 and 2), released when the entry reaches stage 3.
- Data stall active and flush asserted → next cycle all entries are empty, stall=0, and stage 1 holds no copy of the stalled instruction.
